// File: rtl/rrf_pkg.sv
// Shared sizing and types for the renaming register file.
// Indexed by rename tag; each entry carries a result word and its ready bit.
package rrf_pkg;

  localparam int unsigned NUM_ENTRIES = 16;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_TAGS    = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] rrf_tag_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rrf_entry_t;

endpackage

// File: rtl/rrf_read_port.sv
// One combinational operand read port of the renaming register file.
// With RRF_BYPASS_EN defined, a same-cycle writeback to the read tag is forwarded.
module rrf_read_port
  import rrf_pkg::*;
(
  input  rrf_entry_t [NUM_TAGS-1:0] tag_table,
  input  logic [ADDR_W-1:0]         tag,
`ifdef RRF_BYPASS_EN
  input  logic [NUM_TAGS-1:0]       tag_live,
  input  logic                      write_enable,
  input  logic [ADDR_W-1:0]         write_reg,
  input  logic [DATA_W-1:0]         write_data,
  input  logic                      valid_bit,
`endif
  output logic [DATA_W-1:0]         data,
  output logic                      valid
);

  always_comb begin
    data  = tag_table[tag].data;
    valid = tag_table[tag].valid;
`ifdef RRF_BYPASS_EN
    // Out-of-range tags ignore writes, so they must not see the forwarded value either.
    if (write_enable && (write_reg == tag) && tag_live[tag]) begin
      data  = write_data;
      valid = valid_bit;
    end
`endif
  end

endmodule

// File: rtl/renaming_register_file.sv
// Renaming register file: entry array, writeback/allocate update, two operand read ports.
// Optional same-cycle write forwarding is enabled by defining RRF_BYPASS_EN.
module renaming_register_file
  import rrf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              valid_out,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  input  logic              valid_bit,
  input  logic              alloc_enable,
  input  logic [ADDR_W-1:0] alloc_reg
);

  rrf_entry_t [NUM_ENTRIES-1:0] entries_q;
  rrf_entry_t [NUM_TAGS-1:0]    tag_table;
`ifdef RRF_BYPASS_EN
  logic [NUM_TAGS-1:0]          tag_live;
`endif

  // Tags beyond the implemented entries read as an empty, not-ready entry.
  for (genvar i = 0; i < NUM_TAGS; i++) begin : g_table
    if (i < NUM_ENTRIES) begin : g_live
      assign tag_table[i] = entries_q[i];
`ifdef RRF_BYPASS_EN
      assign tag_live[i]  = 1'b1;
`endif
    end else begin : g_dead
      assign tag_table[i] = '0;
`ifdef RRF_BYPASS_EN
      assign tag_live[i]  = 1'b0;
`endif
    end
  end

  // Allocate is applied after the write so it wins the valid bit on a shared tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (write_enable && (write_reg == rrf_tag_t'(i))) begin
          entries_q[i] <= {valid_bit, write_data};
        end
        if (alloc_enable && (alloc_reg == rrf_tag_t'(i))) begin
          entries_q[i].valid <= 1'b0;
        end
      end
    end
  end

  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic              rd1_valid;
  logic              rd2_valid;

  rrf_read_port u_read_port1 (
    .tag_table    (tag_table),
    .tag          (read_reg1),
`ifdef RRF_BYPASS_EN
    .tag_live     (tag_live),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .valid_bit    (valid_bit),
`endif
    .data         (rd1_data),
    .valid        (rd1_valid)
  );

  rrf_read_port u_read_port2 (
    .tag_table    (tag_table),
    .tag          (read_reg2),
`ifdef RRF_BYPASS_EN
    .tag_live     (tag_live),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .valid_bit    (valid_bit),
`endif
    .data         (rd2_data),
    .valid        (rd2_valid)
  );

  // Forcing zero during reset also blocks any forwarded write from leaking out.
  assign read_data1 = reset ? '0 : rd1_data;
  assign read_data2 = reset ? '0 : rd2_data;
  assign valid_out  = ~reset & rd1_valid & rd2_valid;

endmodule

// File: tb/tb_renaming_register_file.sv
// Directed, table-driven bench for renaming_register_file.
module tb_renaming_register_file;

  logic        clk;
  logic        reset;
  logic [3:0]  read_reg1;
  logic [3:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        valid_out;
  logic [3:0]  write_reg;
  logic [31:0] write_data;
  logic        write_enable;
  logic        valid_bit;
  logic        alloc_enable;
  logic [3:0]  alloc_reg;

  int n_checks;
  int n_fail;

  renaming_register_file dut (
    .clk          (clk),
    .reset        (reset),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .valid_out    (valid_out),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_enable (write_enable),
    .valid_bit    (valid_bit),
    .alloc_enable (alloc_enable),
    .alloc_reg    (alloc_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wreg;
    logic [31:0] wdata;
    logic        vbit;
    logic        ae;
    logic [3:0]  areg;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [31:0] exp_d1;
    logic [31:0] exp_d2;
    logic        exp_v;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // {we, wreg, wdata, vbit, ae, areg, r1, r2, exp_d1, exp_d2, exp_v}; reads checked after the edge
    vecs[0]  = '{1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 4'd0,  4'd15, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 4'd2,  32'hDEADBEEF, 1'b1, 1'b0, 4'd0, 4'd0,  4'd2,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 4'd0,  32'h1,        1'b1, 1'b0, 4'd0, 4'd0,  4'd2,  32'h1,        32'hDEADBEEF, 1'b1};
    vecs[3]  = '{1'b1, 4'd4,  32'h44,       1'b1, 1'b0, 4'd0, 4'd4,  4'd1,  32'h44,       32'h0,        1'b0};
    vecs[4]  = '{1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd2, 4'd2,  4'd2,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 4'd2,  32'h5,        1'b1, 1'b1, 4'd2, 4'd2,  4'd2,  32'h5,        32'h5,        1'b0};
    vecs[6]  = '{1'b1, 4'd3,  32'h33,       1'b1, 1'b1, 4'd4, 4'd3,  4'd4,  32'h33,       32'h44,       1'b0};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0, 4'd3,  4'd0,  32'h33,       32'h1,        1'b1};
    vecs[8]  = '{1'b1, 4'd15, 32'hFFFF0000, 1'b0, 1'b0, 4'd0, 4'd15, 4'd0,  32'hFFFF0000, 32'h1,        1'b0};
    vecs[9]  = '{1'b1, 4'd0,  32'hABC,      1'b1, 1'b0, 4'd0, 4'd0,  4'd3,  32'hABC,      32'h33,       1'b1};
    vecs[10] = '{1'b1, 4'd15, 32'h77,       1'b1, 1'b0, 4'd0, 4'd15, 4'd15, 32'h77,       32'h77,       1'b1};

    reset        = 1'b1;
    read_reg1    = 4'd0;
    read_reg2    = 4'd0;
    write_reg    = 4'd0;
    write_data   = 32'h0;
    write_enable = 1'b0;
    valid_bit    = 1'b0;
    alloc_enable = 1'b0;
    alloc_reg    = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      write_enable = vecs[i].we;
      write_reg    = vecs[i].wreg;
      write_data   = vecs[i].wdata;
      valid_bit    = vecs[i].vbit;
      alloc_enable = vecs[i].ae;
      alloc_reg    = vecs[i].areg;
      read_reg1    = vecs[i].r1;
      read_reg2    = vecs[i].r2;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      alloc_enable = 1'b0;
      #1;
      check($sformatf("vec%0d read_data1", i), read_data1, vecs[i].exp_d1);
      check($sformatf("vec%0d read_data2", i), read_data2, vecs[i].exp_d2);
      check($sformatf("vec%0d valid_out", i), {31'b0, valid_out}, {31'b0, vecs[i].exp_v});
    end

    // Same-cycle read of the write target; tag0 holds ABC and is valid
    @(negedge clk);
    write_enable = 1'b1;
    write_reg    = 4'd7;
    write_data   = 32'hCAFE;
    valid_bit    = 1'b1;
    read_reg1    = 4'd7;
    read_reg2    = 4'd0;
    #1;
`ifdef RRF_BYPASS_EN
    check("bypass before edge data", read_data1, 32'hCAFE);
    check("bypass before edge valid", {31'b0, valid_out}, 32'd1);
`else
    check("no-bypass before edge data", read_data1, 32'h0);
    check("no-bypass before edge valid", {31'b0, valid_out}, 32'd0);
`endif
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    #1;
    check("after edge data", read_data1, 32'hCAFE);
    check("after edge valid", {31'b0, valid_out}, 32'd1);

    // Asynchronous reset mid-cycle: outputs clear without a clock edge
    @(negedge clk);
    read_reg1 = 4'd0;
    read_reg2 = 4'd15;
    #1;
    check("pre-reset data1", read_data1, 32'hABC);
    #2;
    reset = 1'b1;
    #1;
    check("reset data1", read_data1, 32'h0);
    check("reset data2", read_data2, 32'h0);
    check("reset valid_out", {31'b0, valid_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    read_reg1 = 4'd7;
    read_reg2 = 4'd0;
    #1;
    check("post-reset data1", read_data1, 32'h0);
    check("post-reset valid_out", {31'b0, valid_out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
